// File: rtl/and_1bit_pkg.sv
// Shared constants for the and_1bit cell: coverage vector width and the
// truth-table bin indices (index = {a[0], b[0]}).
package and_1bit_pkg;

    localparam int unsigned COV_W  = 4;

    localparam int unsigned COV_00 = 0;
    localparam int unsigned COV_01 = 1;
    localparam int unsigned COV_10 = 2;
    localparam int unsigned COV_11 = 3;

    // Map a lane-0 operand pair onto its coverage bin.
    function automatic logic [1:0] cov_idx(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/and_1bit_if.sv
// Operand/result bundle for and_1bit. The master drives operands and the
// coverage clear; the slave (the cell) returns results and coverage state.
interface and_1bit_if #(
    parameter int unsigned WIDTH = 1
);
    import and_1bit_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] z_comb;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             cov_clr;
    logic [COV_W-1:0] cov_seen;
    logic             cov_done;

    modport master (
        output a, b, in_valid, cov_clr,
        input  z_comb, z, z_valid, cov_seen, cov_done
    );

    modport slave (
        input  a, b, in_valid, cov_clr,
        output z_comb, z, z_valid, cov_seen, cov_done
    );

endinterface

// File: rtl/and_1bit_cov.sv
// Lane-0 truth-table coverage tracker: sticky bins set on each valid sample,
// cleared synchronously by clr_i (clear beats a coincident sample).
module and_1bit_cov
    import and_1bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_i,
    input  logic             a0_i,
    input  logic             b0_i,
    input  logic             clr_i,
    output logic [COV_W-1:0] cov_seen_o,
    output logic             cov_done_o
);

    logic [COV_W-1:0] seen_d, seen_q;

    // Next-state: clear has priority, otherwise OR in the sampled bin.
    always_comb begin
        seen_d = seen_q;
        if (clr_i) begin
            seen_d = '0;
        end else if (sample_i) begin
            seen_d[cov_idx(a0_i, b0_i)] = 1'b1;
        end
    end

    // Sticky bin register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign cov_seen_o = seen_q;
    assign cov_done_o = (seen_q == {COV_W{1'b1}});

endmodule

// File: rtl/and_1bit.sv
// Registered bitwise AND cell with a combinational bypass and valid qualifier.
// Define AND_1BIT_COV_EN to build the lane-0 truth-table coverage tracker;
// otherwise the coverage outputs are tied low and cov_clr is ignored.
module and_1bit
    import and_1bit_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic       clk,
    input logic       rst_n,
    and_1bit_if.slave bus
);

    logic [WIDTH-1:0] z_d, z_q;
    logic             z_valid_d, z_valid_q;

    // Capture a & b only on valid samples so X on idle operands never reaches z.
    always_comb begin
        z_d       = z_q;
        z_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            z_d = bus.a & bus.b;
        end
    end

    // Result and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign bus.z_comb  = bus.a & bus.b;
    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;

`ifdef AND_1BIT_COV_EN
    and_1bit_cov u_cov (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (bus.in_valid),
        .a0_i       (bus.a[0]),
        .b0_i       (bus.b[0]),
        .clr_i      (bus.cov_clr),
        .cov_seen_o (bus.cov_seen),
        .cov_done_o (bus.cov_done)
    );
`else
    logic unused_cov_clr;
    assign unused_cov_clr = bus.cov_clr;
    assign bus.cov_seen   = {COV_W{1'b0}};
    assign bus.cov_done   = 1'b0;
`endif

endmodule

// File: tb/tb_and_1bit.sv
// Bench for and_1bit: a 1-lane and a 4-lane instance share stimulus (the
// 1-lane one sees lane 0). Expected registered results go into a queue when
// issued; a monitor pops and compares whenever z_valid is presented.
module tb_and_1bit;

`ifdef AND_1BIT_COV_EN
    localparam bit CovOn = 1'b1;
`else
    localparam bit CovOn = 1'b0;
`endif

    logic clk;
    logic rst_n;

    and_1bit_if #(.WIDTH(1)) bus1 ();
    and_1bit_if #(.WIDTH(4)) bus4 ();

    and_1bit #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    and_1bit #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic v,
                         input logic clr);
        bus4.a        = a;
        bus4.b        = b;
        bus4.in_valid = v;
        bus4.cov_clr  = clr;
        bus1.a        = a[0];
        bus1.b        = b[0];
        bus1.in_valid = v;
        bus1.cov_clr  = clr;
    endtask

    // One cycle of stimulus; exp_comb is the hand-computed a & b.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic v,
                         input logic clr, input logic [3:0] exp_comb);
        @(posedge clk);
        #1;
        drive(a, b, v, clr);
        if (v) exp_q.push_back(exp_comb);
        @(negedge clk);
        check("z_comb4", 32'(bus4.z_comb), 32'(exp_comb));
        check("z_comb1", 32'(bus1.z_comb), 32'(exp_comb[0]));
    endtask

    task automatic check_cov(input string name, input logic [3:0] exp_seen);
        logic [3:0] e;
        e = CovOn ? exp_seen : 4'b0000;
        check({name, " cov_seen4"}, 32'(bus4.cov_seen), 32'(e));
        check({name, " cov_seen1"}, 32'(bus1.cov_seen), 32'(e));
        check({name, " cov_done"}, 32'(bus4.cov_done), 32'(e == 4'b1111));
    endtask

    // Monitor: every presented result must match the oldest outstanding one.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus4.z_valid) begin
                check("z_valid1", 32'(bus1.z_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected z_valid", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("z4", 32'(bus4.z), 32'(mon_exp));
                    check("z1", 32'(bus1.z), 32'(mon_exp[0]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        #100;
        check("reset z4", 32'(bus4.z), 32'd0);
        check("reset z1", 32'(bus1.z), 32'd0);
        check("reset z_valid", 32'(bus4.z_valid), 32'd0);
        check("reset z_comb", 32'(bus4.z_comb), 32'd0);
        check_cov("reset", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table on lane 0: (1,0) (0,1) (1,1) (0,0); upper lanes vary too.
        issue(4'b1101, 4'b1010, 1'b1, 1'b0, 4'b1000);
        issue(4'b0010, 4'b0111, 1'b1, 1'b0, 4'b0010);
        issue(4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111);
        issue(4'b1100, 4'b1010, 1'b1, 1'b0, 4'b1000);
        issue(4'b1111, 4'b0101, 1'b1, 1'b0, 4'b0101);

        // Hold: invalid idle cycles keep z, drop z_valid.
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        check("hold z4", 32'(bus4.z), 32'h5);
        check("hold z1", 32'(bus1.z), 32'd1);
        check("hold z_valid", 32'(bus4.z_valid), 32'd0);
        check_cov("all bins", 4'b1111);

        // Clear with a coincident valid (1,1): clear wins, sample not recorded.
        issue(4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111);
        issue(4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001);
        check_cov("after clr", 4'b0000);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        check_cov("after 11", 4'b1000);

        // Asynchronous reset between edges while z is nonzero.
        check("pre-reset z1", 32'(bus1.z), 32'd1);
        @(posedge clk);
        #2;
        drive(4'b1111, 4'b0011, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async z4", 32'(bus4.z), 32'd0);
        check("async z1", 32'(bus1.z), 32'd0);
        check("async z_valid", 32'(bus4.z_valid), 32'd0);
        check("async z_comb", 32'(bus4.z_comb), 32'h3);
        check_cov("async", 4'b0000);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First sample after release behaves like the first ever.
        issue(4'b0110, 4'b0011, 1'b1, 1'b0, 4'b0010);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        check_cov("post-reset", 4'b0010);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        check("post-reset hold z4", 32'(bus4.z), 32'h2);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
